// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the writeback record used by the
// register-file writeback arbiter and its result buffer.
package mips_pkg;

  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_rec_t;

  // Which requester owns the register-file write port at the coming edge.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MD
  } wbSrc_e;

  // Register 0 is hardwired to zero, so writes to it must never assert RegWrite.
  function automatic logic isWritable(input logic [REG_W-1:0] r);
    return r != '0;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the pipeline / mul-div unit and the register-file
// writeback arbiter; the arbiter uses the slave side.
interface rf_wb_if;
  import mips_pkg::*;

  logic              pipe_we;
  logic [REG_W-1:0]  pipe_wreg;
  logic [DATA_W-1:0] pipe_wdata;
  logic              pipe_stall;

  logic              md_valid;
  logic [REG_W-1:0]  md_wreg;
  logic [DATA_W-1:0] md_wdata;
  logic              md_ready;

  logic              md_issue;
  logic [REG_W-1:0]  md_issue_reg;

  logic [REG_W-1:0]  rs;
  logic [REG_W-1:0]  rt;
  logic              rs_busy;
  logic              rt_busy;

  logic              RegWrite;
  logic [REG_W-1:0]  WriteReg;
  logic [DATA_W-1:0] WriteData;

  modport master (
    output pipe_we, pipe_wreg, pipe_wdata,
    output md_valid, md_wreg, md_wdata,
    output md_issue, md_issue_reg,
    output rs, rt,
    input  pipe_stall, md_ready, rs_busy, rt_busy,
    input  RegWrite, WriteReg, WriteData
  );

  modport slave (
    input  pipe_we, pipe_wreg, pipe_wdata,
    input  md_valid, md_wreg, md_wdata,
    input  md_issue, md_issue_reg,
    input  rs, rt,
    output pipe_stall, md_ready, rs_busy, rt_busy,
    output RegWrite, WriteReg, WriteData
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order FIFO for buffered mul/div results; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign head   = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !rst) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: pipeline writes take priority, mul/div
// results wait in a FIFO, and a starvation guard periodically stalls the pipe.
module rf_wb_arbiter
  import mips_pkg::*;
#(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic     clk,
  input  logic     rst,
  rf_wb_if.slave   bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  wb_rec_t           mdRec;
  wb_rec_t           headRec;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              push;
  logic              pop;
  logic              pipeTaken;
  wbSrc_e            src;

  logic [CNT_W-1:0]    starveCnt;
  logic [CNT_W-1:0]    starveCntNext;
  logic                stallNext;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;
  logic                regWriteNext;
  logic [REG_W-1:0]    writeRegNext;
  logic [DATA_W-1:0]   writeDataNext;

  assign bus.md_ready = !fifoFull && !rst;
  assign push         = bus.md_valid && bus.md_ready;
  assign mdRec        = '{we: isWritable(bus.md_wreg), wreg: bus.md_wreg, data: bus.md_wdata};

  // Bit 0 of busy is held at zero, so register 0 always reads not-busy.
  assign bus.rs_busy  = busy[bus.rs];
  assign bus.rt_busy  = busy[bus.rt];

  wb_fifo #(
    .DEPTH (MD_DEPTH),
    .WIDTH ($bits(wb_rec_t))
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData (mdRec),
    .pop      (pop),
    .head     (headRec),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Arbitration: a taken pipe write wins, otherwise drain the buffer head.
  always_comb begin
    src       = SRC_NONE;
    pipeTaken = bus.pipe_we && !bus.pipe_stall;
    if (pipeTaken)       src = SRC_PIPE;
    else if (!fifoEmpty) src = SRC_MD;
    pop = (src == SRC_MD) && !rst;
  end

  always_comb begin
    starveCntNext = starveCnt;
    stallNext     = 1'b0;
    if (fifoEmpty || src == SRC_MD) begin
      starveCntNext = '0;
    end else if (src == SRC_PIPE) begin
      if (starveCnt == CNT_W'(STARVE_LIMIT - 1)) begin
        starveCntNext = '0;
        stallNext     = 1'b1;
      end else begin
        starveCntNext = starveCnt + CNT_W'(1);
      end
    end
  end

  // A new issue to the same register outranks the clear from a retiring result.
  always_comb begin
    busyNext = busy;
    if (pop && isWritable(headRec.wreg))
      busyNext[headRec.wreg] = 1'b0;
    if (bus.md_issue && isWritable(bus.md_issue_reg))
      busyNext[bus.md_issue_reg] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_comb begin
    regWriteNext  = 1'b0;
    writeRegNext  = bus.WriteReg;
    writeDataNext = bus.WriteData;
    unique case (src)
      SRC_PIPE: begin
        regWriteNext  = isWritable(bus.pipe_wreg);
        writeRegNext  = bus.pipe_wreg;
        writeDataNext = bus.pipe_wdata;
      end
      SRC_MD: begin
        regWriteNext  = headRec.we;
        writeRegNext  = headRec.wreg;
        writeDataNext = headRec.data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.RegWrite   <= 1'b0;
      bus.WriteReg   <= '0;
      bus.WriteData  <= '0;
      bus.pipe_stall <= 1'b0;
      starveCnt      <= '0;
      busy           <= '0;
    end else begin
      bus.RegWrite   <= regWriteNext;
      bus.WriteReg   <= writeRegNext;
      bus.WriteData  <= writeDataNext;
      bus.pipe_stall <= stallNext;
      starveCnt      <= starveCntNext;
      busy           <= busyNext;
    end
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter MD_DEPTH, default 2, SHALL set the depth of the multiply/divide result buffer (power of two, 2..8).
REQ-002 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive pipeline-win cycles tolerated before the buffer is forced through.
REQ-003 Clocking SHALL be one clock, with reset synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 pipe_we / pipe_wreg / pipe_wdata  in  1/5/32  pipeline writeback request, destination, data.
REQ-007 pipe_stall  out  1  registered; when high, the pipe request this cycle is not taken and the pipeline SHALL hold it.
REQ-008 md_valid / md_wreg / md_wdata  in  1/5/32  mul/div result offer; md_ready  out  1  buffer can accept.
REQ-009 md_issue / md_issue_reg  in  1/5  mul/div op issued; marks its destination pending.
REQ-010 rs / rt  in  5 each  read addresses; rs_busy / rt_busy  out  1 each  addressed register has a pending mul/div write.
REQ-011 RegWrite / WriteReg / WriteData  out  1/5/32  registered register-file write port.

Function
REQ-012 A pipe write SHALL be taken at an edge when pipe_we=1 and pipe_stall=0; its RF write SHALL appear on the outputs for the cycle after that edge (1-cycle latency).
REQ-013 An md result SHALL be pushed into the FIFO at an edge when md_valid=1 and md_ready=1.
REQ-014 md_ready SHALL equal not-full, SHALL be derived from state only, and SHALL be 0 while rst=1.
REQ-015 A pushed result SHALL never be written at the push edge; its earliest RF write SHALL appear on the outputs for the cycle after the following edge.
REQ-016 Arbitration at each edge:
  - if a pipe write is taken, it SHALL load the outputs;
  - else if the FIFO is non-empty, the head SHALL be popped and loaded;
  - else RegWrite SHALL be 0 next cycle.
REQ-017 Writes targeting register 0 (pipe or md) SHALL consume their slot but drive RegWrite=0.
REQ-018 The FIFO SHALL be strictly in order; a simultaneous push and pop SHALL be legal when not full, with occupancy unchanged.
REQ-019 Starvation counter:
  - SHALL increment at each edge where the FIFO is non-empty and a pipe write wins;
  - SHALL clear on any pop or when the FIFO is empty;
  - on reaching STARVE_LIMIT, pipe_stall SHALL be 1 for exactly the next cycle, forcing a pop, and the counter SHALL clear.
REQ-020 Scoreboard busy[31:1]:
  - md_issue SHALL set busy[md_issue_reg] (register 0 ignored);
  - an md pop loading register r SHALL clear busy[r];
  - if the set and clear hit the same register at the same edge, set SHALL win.
REQ-021 rs_busy / rt_busy SHALL be combinational lookups of busy; address 0 SHALL read 0.
REQ-022 Pipe writes SHALL NOT alter busy bits.

Reset
REQ-023 On rst=1 at an edge:
  - RegWrite, WriteReg, WriteData and pipe_stall SHALL be 0;
  - the FIFO SHALL be emptied;
  - all busy bits and the starvation counter SHALL clear.
REQ-024 Reset mid-operation SHALL discard buffered results without writing them, and pipe/md inputs at that edge SHALL be ignored.

Structure
REQ-025 Shared package mips_pkg SHALL hold REG_W=5, DATA_W=32, NUM_REGS=32 and the writeback record type {we, reg, data}.
REQ-026 The FIFO SHALL be a sub-module wb_fifo (parameterised depth and width; push/pop/full/empty/head).

Verification
REQ-027 Basic pipe write:
  - stimulus: pipe_we=1, pipe_wreg=5, pipe_wdata=0x1234, FIFO empty;
  - required: next cycle RegWrite=1, WriteReg=5, WriteData=0x1234.
REQ-028 Buffered md write with scoreboard:
  - stimulus: md_issue reg 9; later md result reg 9 = 0xABCD with no pipe traffic;
  - required: rs=9 gives rs_busy=1 until the write appears two edges after the push; rs_busy=0 from that cycle.
REQ-029 Starvation guard:
  - stimulus: FIFO holds one entry; pipe_we=1 continuously (MD_DEPTH=2, STARVE_LIMIT=4);
  - required: 4 pipe writes, then pipe_stall=1 for one cycle, the md entry written, and the held pipe request written the cycle after.
REQ-030 Full FIFO:
  - stimulus: 2 md results pushed while pipe_we=1;
  - required: md_ready=0 and a third md_valid is not accepted until the first pop.
REQ-031 Register 0:
  - stimulus: pipe write to reg 0, and md_issue/md result to reg 0;
  - required: RegWrite stays 0; busy and rs_busy for 0 stay 0.
REQ-032 Reset mid-operation:
  - stimulus: FIFO holding 2 entries and busy[3]=1 when rst is pulsed for 1 cycle;
  - required: no RF write of the buffered data; all outputs 0; md_ready=1 after rst falls.
